wb_dest_queue: RTL and testbench
================================

Name: wb_dest_queue

Overview:
Parametrised successor to the register-destination mux in the multi-cycle MIPS datapath. It selects the write-back destination index from five sources: link register, stack pointer, rd, rt and rs. It pairs the index with write data and buffers pending register-file writes in a DEPTH-entry FIFO. It drains them to the register file over a valid/ready handshake and exposes a pending-write lookup for hazard detection. It sits between the control unit / ALUOut stage and the register file write port.

Parameters:
AW, 5, register index width
DW, 32, write data width
DEPTH, 4, FIFO entries; power of two, >= 2
LINK_REG, 31, index driven for dst_sel=000
SP_REG, 29, index driven for dst_sel=001
DROP_ZERO, 1, when 1, writes to index 0 are accepted but discarded

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  write request present
in_ready  output  1  queue can accept; equals (count < DEPTH)
dst_sel  input  3  000 LINK_REG, 001 SP_REG, 010 rd_field, 011 rt_field, 100 rs_field, 101-111 invalid
rs_field  input  AW  IR[25:21]
rt_field  input  AW  IR[20:16]
rd_field  input  AW  IR[15:11]
wdata  input  DW  data to write
out_valid  output  1  head entry present (count != 0)
out_ready  input  1  register file consumes head
out_addr  output  AW  head destination index; 0 when out_valid=0
out_data  output  DW  head data; 0 when out_valid=0
query_addr  input  AW  index to check for pending write
query_hit  output  1  some stored entry targets query_addr
count  output  $clog2(DEPTH+1)  entries stored
sel_err  output  1  sticky invalid-select flag
err_clr  input  1  clears sel_err

Behaviour:
- Reset (async, reset_n=0): count=0, read/write pointers=0, sel_err=0, out_valid=0, out_addr=0, out_data=0, query_hit=0. Entry storage need not be reset. Reset mid-operation discards all entries immediately.
- Accept: a handshake occurs when in_valid && in_ready, evaluated at the rising edge.
- Store condition: the entry is written at the tail only if dst_sel is valid and NOT (DROP_ZERO && selected index==0).
  - Invalid dst_sel: handshake completes, nothing stored, sel_err set on that edge.
  - Zero-index drop: handshake completes, nothing stored, no error.
- Selected index: a pure function of dst_sel and the fields in the accept cycle. Constants are truncated to AW bits.
- Pop: when out_valid && out_ready, the head advances.
- Push and pop in the same cycle: count unchanged, both pointers advance. Not possible when full, since in_ready=0 (no pass-through).
- Latency: entry stored at edge N appears on out_* in cycle N+1 (registered storage, first-word-fall-through). Entries drain in FIFO order, at most one per cycle.
- Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0. Popping when empty and pushing when full cannot occur by handshake rules.
- query_hit: combinational OR over stored entries (count entries from the head) of (addr==query_addr). Reflects state before the current edge. An entry popping this cycle still counts; an entry pushing this cycle does not.
  - query_addr=0 with DROP_ZERO=1: always 0.
- sel_err: set wins over err_clr in the same cycle; err_clr alone clears it on the next edge.
- in_ready and out_valid are derived only from registered count, with no combinational path from the inputs.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, out_addr=0, out_data=0, sel_err=0. Assert reset_n low mid-burst with 3 entries -> count=0 immediately, without waiting for a clock edge.
- Push dst_sel=000, wdata=0xDEADBEEF with out_ready=0 -> next cycle out_valid=1, out_addr=31, out_data=0xDEADBEEF, count=1. Then push dst_sel=011, rt_field=7, wdata=5 -> count=2, query_addr=7 gives query_hit=1, query_addr=8 gives 0.
- Push 4 entries (rd=1..4, data 10..40) with out_ready=0 -> count=4, in_ready=0, a 5th in_valid is ignored. Raise out_ready -> out_addr 1,2,3,4 with data 10..40 on consecutive cycles, then out_valid=0.
- Wrap-around: push/pop continuously for 10 cycles, including simultaneous push+pop at count=2 -> count stays 2, order preserved across the pointer wrap.
- dst_sel=110 push -> nothing stored, count unchanged, sel_err=1. err_clr with a concurrent dst_sel=111 push -> sel_err remains 1; err_clr alone -> sel_err=0.
- DROP_ZERO=1: push dst_sel=010 with rd_field=0 -> in_ready handshake completes, count unchanged, sel_err=0. Rerun with DROP_ZERO=0 -> entry with out_addr=0 stored.

Source files
------------

// File: rtl/wb_dest_queue.sv
// Write-back destination selector feeding a small FIFO of pending register-file writes.
// Also flags invalid selects and answers "is a write to this index still pending?".
module wb_dest_queue #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int LINK_REG  = 31,
    parameter int SP_REG    = 29,
    parameter int DROP_ZERO = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   dst_sel,
    input  logic [AW-1:0]                rs_field,
    input  logic [AW-1:0]                rt_field,
    input  logic [AW-1:0]                rd_field,
    input  logic [DW-1:0]                wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AW-1:0]                out_addr,
    output logic [DW-1:0]                out_data,
    input  logic [AW-1:0]                query_addr,
    output logic                         query_hit,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         sel_err,
    input  logic                         err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] sel_idx;
    logic          sel_ok;
    logic          accept;
    logic          store;
    logic          pop;

    always_comb begin
        sel_idx = '0;
        sel_ok  = 1'b1;
        case (dst_sel)
            3'b000:  sel_idx = AW'(LINK_REG);
            3'b001:  sel_idx = AW'(SP_REG);
            3'b010:  sel_idx = rd_field;
            3'b011:  sel_idx = rt_field;
            3'b100:  sel_idx = rs_field;
            default: sel_ok  = 1'b0;
        endcase
    end

    // Both sides use valid/ready: a transfer happens on a rising edge where valid && ready;
    // ready/valid outputs come from registered count only, so no input-to-output loop exists.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign store     = accept && sel_ok && !((DROP_ZERO != 0) && (sel_idx == '0));
    assign pop       = out_valid && out_ready;

    assign out_addr  = out_valid ? addr_mem[rd_ptr] : '0;
    assign out_data  = out_valid ? data_mem[rd_ptr] : '0;

    // Only the count live entries starting at the head take part in the lookup.
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (addr_mem[rd_ptr + PW'(i)] == query_addr))
                query_hit = 1'b1;
        end
        if ((DROP_ZERO != 0) && (query_addr == '0))
            query_hit = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sel_err <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new invalid select takes priority over a clear request.
            if (accept && !sel_ok)
                sel_err <= 1'b1;
            else if (err_clr)
                sel_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            addr_mem[wr_ptr] <= sel_idx;
            data_mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: tb/tb_wb_dest_queue.sv
// Bench for wb_dest_queue: directed scenarios plus random traffic against a queue model.
module tb_wb_dest_queue;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic [2:0]    dst_sel;
    logic [AW-1:0] rs_field;
    logic [AW-1:0] rt_field;
    logic [AW-1:0] rd_field;
    logic [DW-1:0] wdata;
    logic          out_ready;
    logic [AW-1:0] query_addr;
    logic          err_clr;

    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          query_hit;
    logic [CW-1:0] count;
    logic          sel_err;

    logic          nz_in_ready;
    logic          nz_out_valid;
    logic [AW-1:0] nz_out_addr;
    logic [DW-1:0] nz_out_data;
    logic          nz_query_hit;
    logic [CW-1:0] nz_count;
    logic          nz_sel_err;

    logic [AW+DW-1:0] exp_q[$];
    logic             model_err;
    int               checks;
    int               errors;

    wb_dest_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LINK_REG(31), .SP_REG(29), .DROP_ZERO(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .dst_sel(dst_sel), .rs_field(rs_field), .rt_field(rt_field), .rd_field(rd_field),
        .wdata(wdata), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .query_addr(query_addr), .query_hit(query_hit), .count(count),
        .sel_err(sel_err), .err_clr(err_clr)
    );

    wb_dest_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LINK_REG(31), .SP_REG(29), .DROP_ZERO(0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(nz_in_ready),
        .dst_sel(dst_sel), .rs_field(rs_field), .rt_field(rt_field), .rd_field(rd_field),
        .wdata(wdata), .out_valid(nz_out_valid), .out_ready(out_ready), .out_addr(nz_out_addr),
        .out_data(nz_out_data), .query_addr(query_addr), .query_hit(nz_query_hit), .count(nz_count),
        .sel_err(nz_sel_err), .err_clr(err_clr)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference destination rule: {valid, index}.
    function automatic logic [AW:0] ref_sel(input logic [2:0] sel, input logic [AW-1:0] rs,
                                            input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        case (sel)
            3'd0:    return {1'b1, AW'(31)};
            3'd1:    return {1'b1, AW'(29)};
            3'd2:    return {1'b1, rd};
            3'd3:    return {1'b1, rt};
            3'd4:    return {1'b1, rs};
            default: return {1'b0, {AW{1'b0}}};
        endcase
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_query_hit", query_hit, 0);
        chk("rst_nz_count", nz_count, 0);
        exp_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // driver: called at posedge+1, checks status mid-cycle, updates the model at the edge
    task automatic cycle(input logic v, input logic [2:0] sel, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                         input logic ordy, input logic [AW-1:0] qa, input logic clr);
        int         cnt_now;
        logic       hit;
        logic [AW:0] r;
        in_valid   = v;
        dst_sel    = sel;
        rs_field   = rs;
        rt_field   = rt;
        rd_field   = rd;
        wdata      = d;
        out_ready  = ordy;
        query_addr = qa;
        err_clr    = clr;
        #1;
        cnt_now = exp_q.size();
        hit = 1'b0;
        foreach (exp_q[k])
            if (exp_q[k][AW+DW-1:DW] == qa) hit = 1'b1;
        chk("count", count, cnt_now);
        chk("in_ready", in_ready, cnt_now < DEPTH);
        chk("out_valid", out_valid, cnt_now != 0);
        chk("sel_err", sel_err, model_err);
        chk("query_hit", query_hit, hit);
        @(posedge clk);
        r = ref_sel(sel, rs, rt, rd);
        if (v && cnt_now < DEPTH && !r[AW]) model_err = 1'b1;
        else if (clr) model_err = 1'b0;
        if (v && cnt_now < DEPTH && r[AW] && r[AW-1:0] != '0)
            exp_q.push_back({r[AW-1:0], d});
        #1;
    endtask

    // monitor: compares the head against the scoreboard and retires it on a handshake
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=valid expected=empty at %0t", $time);
                    end else begin
                        chk("out_addr", out_addr, exp_q[0][AW+DW-1:DW]);
                        chk("out_data", out_data, exp_q[0][DW-1:0]);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("idle_out_addr", out_addr, 0);
                    chk("idle_out_data", out_data, 0);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        model_err = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        dst_sel   = '0;
        rs_field  = '0;
        rt_field  = '0;
        rd_field  = '0;
        wdata     = '0;
        out_ready = 1'b0;
        query_addr = '0;
        err_clr   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);

        // link register push, then rt push and lookups
        cycle(1, 3'd0, 0, 0, 0, 32'hDEADBEEF, 0, 31, 0);
        cycle(1, 3'd3, 0, 7, 0, 32'd5, 0, 31, 0);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 7, 0);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 8, 0);
        for (int i = 0; i < 3; i++) cycle(0, 3'd0, 0, 0, 0, 0, 1, 7, 0);

        // fill to DEPTH, ignored 5th request, then drain
        for (int i = 1; i <= 4; i++) cycle(1, 3'd2, 0, 0, AW'(i), DW'(i * 10), 0, AW'(i), 0);
        cycle(1, 3'd2, 0, 0, 5, 32'd50, 0, 5, 0);
        for (int i = 0; i < 5; i++) cycle(0, 3'd0, 0, 0, 0, 0, 1, 4, 0);

        // asynchronous reset with three entries pending
        for (int i = 1; i <= 3; i++) cycle(1, 3'd4, AW'(i + 8), 0, 0, DW'(i), 0, 0, 0);
        do_reset();
        cycle(0, 3'd0, 0, 0, 0, 0, 1, 9, 0);

        // wrap-around with simultaneous push and pop at count=2
        cycle(1, 3'd2, 0, 0, 20, 32'd200, 0, 20, 0);
        cycle(1, 3'd2, 0, 0, 21, 32'd210, 0, 21, 0);
        for (int i = 0; i < 10; i++) cycle(1, 3'd2, 0, 0, AW'(i + 2), $urandom, 1, AW'(i), 0);
        for (int i = 0; i < 3; i++) cycle(0, 3'd0, 0, 0, 0, 0, 1, 0, 0);

        // invalid select is sticky; set beats clear
        cycle(1, 3'd6, 3, 3, 3, 32'd1, 0, 3, 0);
        cycle(1, 3'd7, 3, 3, 3, 32'd2, 0, 3, 1);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 3, 1);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 3, 0);

        // zero-index: dropped when DROP_ZERO=1, stored when DROP_ZERO=0
        do_reset();
        cycle(1, 3'd2, 0, 0, 0, 32'h55, 0, 0, 0);
        chk("nz_count", nz_count, 1);
        chk("nz_out_valid", nz_out_valid, 1);
        chk("nz_out_addr", nz_out_addr, 0);
        chk("nz_out_data", nz_out_data, 32'h55);
        chk("nz_query_hit", nz_query_hit, 1);
        chk("nz_sel_err", nz_sel_err, 0);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0]    s;
            logic [AW-1:0] rd;
            int            pick;
            pick = $urandom_range(0, 10);
            s    = (pick > 7) ? 3'd2 : 3'(pick);
            rd   = AW'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), s, AW'($urandom), AW'($urandom), rd, $urandom,
                  1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 1) != 0) ? rd : AW'($urandom),
                  1'($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 6; i++) cycle(0, 3'd0, 0, 0, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
